// File: rtl/axi3_rd_slave.sv
// AXI3 read-path responder: one outstanding AR burst (FIXED/INCR/WRAP, 1-16 beats) served from a
// backdoor-loaded word memory. Define AXI3_RD_SLV_ERR_EN to return SLVERR beats for illegal accesses.
module axi3_rd_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LEN   = 4,
  parameter int MEM_DEPTH  = 256,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int BSH       = $clog2(BYTES),
  localparam int MSH       = $clog2(MEM_DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [ADDR_LEN-1:0]   arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  mem_we,
  input  logic [MSH-1:0]        mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_LEN-1:0]   len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_LEN-1:0]   beat_q, beat_d;

  logic                  ar_fire, r_fire;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  ld;
  logic [MSH-1:0]        ld_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // WRAP only wraps for 2/4/8/16-beat bursts; everything else that is not FIXED increments.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_LEN-1:0]   len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    logic                  wrap_ok;
    step    = ADDR_WIDTH'(1) << size;
    inc     = a + step;
    mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    wrap_ok = (len == ADDR_LEN'(1)) || (len == ADDR_LEN'(3)) ||
              (len == ADDR_LEN'(7)) || (len == ADDR_LEN'(15));
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = wrap_ok ? ((a & ~mask) | (inc & mask)) : inc;
      default: next_addr = inc;
    endcase
  endfunction

`ifdef AXI3_RD_SLV_ERR_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  function automatic logic beat_err(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    beat_err = ({1'b0, a} >= MEM_BYTES) || (size > 3'(BSH)) || (burst == 2'b11);
  endfunction

  logic ld_err;
`endif

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    ld        = 1'b0;
    ld_idx    = '0;
`ifdef AXI3_RD_SLV_ERR_EN
    ld_err    = 1'b0;
`endif

    ar_fire  = (state_q == S_IDLE) && arready_q && arvalid;
    r_fire   = (state_q == S_SEND) && rvalid_q && rready;
    addr_nxt = next_addr(addr_q, len_q, size_q, burst_q);

    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        if (ar_fire) begin
          state_d   = S_SEND;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == '0);
          rid_d     = arid;
          addr_d    = araddr;
          len_d     = arlen;
          size_d    = arsize;
          burst_d   = arburst;
          beat_d    = '0;
          ld        = 1'b1;
          ld_idx    = araddr[BSH +: MSH];
`ifdef AXI3_RD_SLV_ERR_EN
          ld_err    = beat_err(araddr, arsize, arburst);
`endif
        end
      end
      default: begin
        arready_d = 1'b0;
        if (r_fire) begin
          if (rlast_q) begin
            state_d   = S_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            addr_d  = addr_nxt;
            beat_d  = beat_q + ADDR_LEN'(1);
            rlast_d = ((beat_q + ADDR_LEN'(1)) == len_q);
            ld      = 1'b1;
            ld_idx  = addr_nxt[BSH +: MSH];
`ifdef AXI3_RD_SLV_ERR_EN
            ld_err  = beat_err(addr_nxt, size_q, burst_q);
`endif
          end
        end
      end
    endcase

    // The memory read lands directly in the output register, so a write on the same edge sees old data.
    if (ld) begin
      rdata_d = mem[ld_idx];
      rresp_d = 2'b00;
`ifdef AXI3_RD_SLV_ERR_EN
      if (ld_err) begin
        rdata_d = '0;
        rresp_d = 2'b10;
      end
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule
